// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
// Memory-mapped UART transmitter on the core's data bus. Bytes written to
// TXDATA are queued in a small circular FIFO and sent on `tx` as 8N1 frames.
// Define UART_TX_PARITY_EN to build 8E1 frames instead, which adds an
// even-parity bit between the data bits and the stop bit.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   reset      asynchronous, active-low reset
//   MemWrite   bus write strobe from the core
//   Adr        bus address from the core
//   WriteData  bus write data from the core
//   Sel        combinational; high when Adr falls inside the 16-byte window
//   RdData     combinational read data; zero when Sel is low
//   tx         registered serial line; idles high
//
// Register map (Adr[3:2]; Adr[1:0] ignored):
//   0x0 TXDATA  write pushes WriteData[7:0]; reads return 0
//   0x4 STATUS  {count[7:4], overflow, empty, full, busy}; write bit3=1 clears overflow
//   0x8, 0xC    reads return 0; writes are ignored
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Adr,
  input  logic [31:0] WriteData,
  output logic        Sel,
  output logic [31:0] RdData,
  output logic        tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } txState_t;

  txState_t          state;
  logic [BAUD_W-1:0] baudCnt;
  logic [2:0]        bitCnt;
  logic [7:0]        shiftReg;
`ifdef UART_TX_PARITY_EN
  logic              parityBit;
`endif

  logic [7:0]        fifoMem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [CNT_W-1:0]  fifoCount;
  logic              overflow;

  logic              fifoFull;
  logic              fifoEmpty;
  logic              baudDone;
  logic              popReq;
  logic              pushReq;
  logic              pushAccept;
  logic              clrReq;
  logic [7:0]        fifoHead;
  logic [31:0]       status;
  logic              unusedBits;

  // Address decode and bus strobes. A push into a full FIFO is still taken
  // when the transmitter pops in the same cycle, because a slot frees up on
  // that same edge.
  assign Sel        = (Adr[31:4] == BASE_ADDR[31:4]);
  assign pushReq    = Sel & MemWrite & (Adr[3:2] == 2'd0);
  assign clrReq     = Sel & MemWrite & (Adr[3:2] == 2'd1) & WriteData[3];
  assign fifoFull   = (fifoCount == CNT_W'(FIFO_DEPTH));
  assign fifoEmpty  = (fifoCount == '0);
  assign baudDone   = (baudCnt == '0);
  assign popReq     = !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudDone));
  assign pushAccept = pushReq && (!fifoFull || popReq);
  assign fifoHead   = fifoMem[rdPtr];
  assign unusedBits = ^{Adr[1:0], WriteData[31:8]};

  // STATUS is assembled straight from live register state, so a read in the
  // cycle right after a push already shows the new count.
  assign status = {24'd0, 4'(fifoCount), overflow, fifoEmpty, fifoFull, (state != IDLE)};

  // Read mux: only STATUS returns data, everything else in or out of the
  // window reads as zero.
  always_comb begin
    RdData = '0;
    if (Sel && (Adr[3:2] == 2'd1)) begin
      RdData = status;
    end
  end

  // FIFO storage carries no reset; the pointers and count define what is
  // valid, so clearing them on reset discards whatever was queued.
  always_ff @(posedge clk) begin
    if (pushAccept) begin
      fifoMem[wrPtr] <= WriteData[7:0];
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because the depth is a power of two. A simultaneous push and
  // pop leaves the count unchanged. A clear always beats a new overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      overflow  <= 1'b0;
    end else begin
      if (pushAccept) begin
        wrPtr <= wrPtr + PTR_W'(1);
      end
      if (popReq) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      case ({pushAccept, popReq})
        2'b10:   fifoCount <= fifoCount + CNT_W'(1);
        2'b01:   fifoCount <= fifoCount - CNT_W'(1);
        default: fifoCount <= fifoCount;
      endcase
      if (clrReq) begin
        overflow <= 1'b0;
      end else if (pushReq && fifoFull && !popReq) begin
        overflow <= 1'b1;
      end
    end
  end

  // Transmit state machine. Every state or bit change reloads the baud
  // counter, which then counts down to zero, so each bit lasts exactly
  // CLKS_PER_BIT cycles. Data shifts out LSB first. At the end of STOP,
  // a waiting byte is popped and its start bit begins on the same edge,
  // which keeps back-to-back frames free of idle gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baudCnt   <= '0;
      bitCnt    <= '0;
      shiftReg  <= '0;
`ifdef UART_TX_PARITY_EN
      parityBit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (popReq) begin
            shiftReg  <= fifoHead;
`ifdef UART_TX_PARITY_EN
            parityBit <= ^fifoHead;
`endif
            state     <= START;
            tx        <= 1'b0;
            baudCnt   <= BAUD_RELOAD;
          end
        end
        START: begin
          if (baudDone) begin
            state   <= DATA;
            tx      <= shiftReg[0];
            bitCnt  <= '0;
            baudCnt <= BAUD_RELOAD;
          end else begin
            baudCnt <= baudCnt - BAUD_W'(1);
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= BAUD_RELOAD;
            if (bitCnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parityBit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitCnt   <= bitCnt + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              tx       <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt - BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baudDone) begin
            state   <= STOP;
            tx      <= 1'b1;
            baudCnt <= BAUD_RELOAD;
          end else begin
            baudCnt <= baudCnt - BAUD_W'(1);
          end
        end
`endif
        STOP: begin
          if (baudDone) begin
            if (popReq) begin
              shiftReg  <= fifoHead;
`ifdef UART_TX_PARITY_EN
              parityBit <= ^fifoHead;
`endif
              state     <= START;
              tx        <= 1'b0;
              baudCnt   <= BAUD_RELOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            baudCnt <= baudCnt - BAUD_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Bytes expected on the line are queued when they are written, and a serial
// monitor decodes every frame on tx and compares it against the queue head.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYCLES = FRAME_BITS * CPB;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Adr = '0;
  logic [31:0] WriteData = '0;
  logic        Sel;
  logic [31:0] RdData;
  logic        tx;

  int          checks = 0;
  int          passes = 0;
  int          cycleCount = 0;
  logic [7:0]  expQ[$];
  int          frameStarts[$];
  bit          resetSeen = 1'b0;

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .MemWrite (MemWrite),
    .Adr      (Adr),
    .WriteData(WriteData),
    .Sel      (Sel),
    .RdData   (RdData),
    .tx       (tx)
  );

  // Free-running clock and a cycle counter used to timestamp frame starts.
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Any reset pulse aborts the frame the monitor is decoding.
  always @(negedge reset) resetSeen = 1'b1;

  // Drive one bus write for exactly one rising edge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    Adr       = a;
    WriteData = d;
    MemWrite  = 1'b1;
    @(negedge clk);
    MemWrite  = 1'b0;
  endtask

  // Combinational read of RdData and Sel for a given address.
  task automatic busRead(input logic [31:0] a, output logic [31:0] d, output logic s);
    Adr      = a;
    MemWrite = 1'b0;
    #1;
    d = RdData;
    s = Sel;
  endtask

  // Decode one frame whose start bit was first seen on this falling edge,
  // sampling each bit in the middle of its bit time.
  task automatic decodeFrame();
    logic [7:0] data;
    logic       exp;
    logic       startOk;
    logic       stopOk;
    logic       parityOk;
    logic [7:0] expByte;
    data = '0;
    resetSeen = 1'b0;
    frameStarts.push_back(cycleCount);
    repeat (CPB / 2) @(negedge clk);
    if (resetSeen) return;
    startOk = (tx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      if (resetSeen) return;
      data[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB) @(negedge clk);
    if (resetSeen) return;
    exp = ^data;
    parityOk = (tx === exp);
`else
    exp = 1'b0;
    parityOk = 1'b1;
`endif
    repeat (CPB) @(negedge clk);
    if (resetSeen) return;
    stopOk = (tx === 1'b1);
    checks++;
    if ({startOk, parityOk, stopOk} !== 3'b111) begin
      $display("[TB] FAIL frame_framing: start/parity/stop ok=%b%b%b (parity exp %b), required 111",
               startOk, parityOk, stopOk, exp);
    end else begin
      passes++;
    end
    checks++;
    if (expQ.size() == 0) begin
      $display("[TB] FAIL frame_data: got unexpected byte 0x%02h, required no frame", data);
    end else begin
      expByte = expQ.pop_front();
      if (data !== expByte) begin
        $display("[TB] FAIL frame_data: got 0x%02h, required 0x%02h", data, expByte);
      end else begin
        passes++;
      end
    end
  endtask

  // Serial line monitor: any low level on an idle line is a start bit.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) decodeFrame();
    end
  end

  // Wait, with a cycle budget, until the transmitter is idle with an empty
  // FIFO and every queued byte has been seen on the line.
  task automatic waitDrain(input int budget, input string name);
    logic [31:0] st;
    logic        s;
    int          n;
    n = 0;
    busRead(BASE + 32'h4, st, s);
    while ((st !== 32'h4 || expQ.size() != 0) && n < budget) begin
      @(negedge clk);
      busRead(BASE + 32'h4, st, s);
      n++;
    end
    checks++;
    if (st !== 32'h4 || expQ.size() != 0) begin
      $display("[TB] FAIL %s: status 0x%08h with %0d bytes outstanding after %0d cycles, required 0x00000004 and 0",
               name, st, expQ.size(), n);
    end else begin
      passes++;
    end
  endtask

  // Reset state, then an asynchronous reset in the middle of a frame.
  task automatic test_reset();
    logic [31:0] st;
    logic        s;
    logic        sawLow;
    int          n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) $display("[TB] FAIL reset_tx: got %b, required 1", tx);
    else passes++;
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h4) $display("[TB] FAIL reset_status: got 0x%08h, required 0x00000004", st);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    busWrite(BASE, 32'h3C);
    expQ.push_back(8'h3C);
    n = 0;
    while (tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx !== 1'b0) $display("[TB] FAIL reset_frame_start: tx %b after %0d cycles, required 0", tx, n);
    else passes++;
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) $display("[TB] FAIL reset_async_tx: got %b, required 1", tx);
    else passes++;
    @(negedge clk);
    reset = 1'b1;
    expQ.delete();
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h4) $display("[TB] FAIL reset_status_after: got 0x%08h, required 0x00000004", st);
    else passes++;
    sawLow = 1'b0;
    repeat (FRAME_CYCLES + 5) begin
      @(negedge clk);
      if (tx !== 1'b1) sawLow = 1'b1;
    end
    checks++;
    if (sawLow !== 1'b0) $display("[TB] FAIL reset_fifo_discard: line activity %b, required 0", sawLow);
    else passes++;
  endtask

  // Address decode, read-as-zero registers and ignored writes.
  task automatic test_decode();
    logic [31:0] d;
    logic        s;
    busRead(BASE + 32'h8, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b1)
      $display("[TB] FAIL decode_base8: RdData 0x%08h Sel %b, required 0x00000000 Sel 1", d, s);
    else passes++;
    busRead(32'h0000_0100, d, s);
    checks++;
    if (d !== 32'h0 || s !== 1'b0)
      $display("[TB] FAIL decode_outside: RdData 0x%08h Sel %b, required 0x00000000 Sel 0", d, s);
    else passes++;
    busRead(BASE, d, s);
    checks++;
    if (d !== 32'h0) $display("[TB] FAIL decode_txdata_read: got 0x%08h, required 0x00000000", d);
    else passes++;
    busRead(BASE + 32'h5, d, s);
    checks++;
    if (d !== 32'h4) $display("[TB] FAIL decode_low_bits: got 0x%08h, required 0x00000004", d);
    else passes++;
    busWrite(BASE + 32'hC, 32'h5A);
    busWrite(32'h0000_0100, 32'h5A);
    busWrite(BASE + 32'h8, 32'h5A);
    busRead(BASE + 32'h4, d, s);
    checks++;
    if (d !== 32'h4) $display("[TB] FAIL decode_ignored_writes: status 0x%08h, required 0x00000004", d);
    else passes++;
  endtask

  // One byte: write-to-line latency, status while sending, frame length.
  task automatic test_single_frame(input logic [7:0] b, input string name);
    logic [31:0] st;
    logic        s;
    busWrite(BASE, {24'd0, b});
    expQ.push_back(b);
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h10) $display("[TB] FAIL %s_status_after_push: got 0x%08h, required 0x00000010", name, st);
    else passes++;
    checks++;
    if (tx !== 1'b1) $display("[TB] FAIL %s_tx_before_pop: got %b, required 1", name, tx);
    else passes++;
    @(negedge clk);
    checks++;
    if (tx !== 1'b0) $display("[TB] FAIL %s_tx_start: got %b, required 0", name, tx);
    else passes++;
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h5) $display("[TB] FAIL %s_status_sending: got 0x%08h, required 0x00000005", name, st);
    else passes++;
    repeat (FRAME_CYCLES - 1) @(negedge clk);
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st[0] !== 1'b1) $display("[TB] FAIL %s_busy_last_cycle: got %b, required 1", name, st[0]);
    else passes++;
    @(negedge clk);
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h4) $display("[TB] FAIL %s_status_done: got 0x%08h, required 0x00000004", name, st);
    else passes++;
    waitDrain(FRAME_CYCLES, {name, "_drain"});
  endtask

  // Three consecutive writes: push/pop on a one-entry FIFO, then three
  // contiguous frames with no idle gap between them.
  task automatic test_back_to_back();
    logic [31:0] st;
    logic        s;
    logic [7:0]  bytes [3];
    bytes[0] = 8'hA1;
    bytes[1] = 8'hB2;
    bytes[2] = 8'hC3;
    frameStarts.delete();
    for (int i = 0; i < 3; i++) begin
      busWrite(BASE, {24'd0, bytes[i]});
      expQ.push_back(bytes[i]);
    end
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h21) $display("[TB] FAIL b2b_status_count: got 0x%08h, required 0x00000021", st);
    else passes++;
    waitDrain(3 * FRAME_CYCLES + 20, "b2b_drain");
    checks++;
    if (frameStarts.size() != 3) begin
      $display("[TB] FAIL b2b_frame_count: got %0d, required 3", frameStarts.size());
    end else begin
      passes++;
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (frameStarts[i] - frameStarts[i-1] != FRAME_CYCLES)
          $display("[TB] FAIL b2b_gap%0d: start spacing %0d cycles, required %0d",
                   i, frameStarts[i] - frameStarts[i-1], FRAME_CYCLES);
        else passes++;
      end
    end
  endtask

  // Overflow while busy, clearing it, and a push into a full FIFO on the
  // same edge the transmitter pops.
  task automatic test_overflow();
    logic [31:0] st;
    logic        s;
    int          c0;
    busWrite(BASE, 32'h11);
    expQ.push_back(8'h11);
    c0 = cycleCount;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      busWrite(BASE, 32'h21 + i);
      if (i < DEPTH) expQ.push_back(8'h21 + 8'(i));
    end
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h4B) $display("[TB] FAIL ovf_status_set: got 0x%08h, required 0x0000004B", st);
    else passes++;
    busWrite(BASE + 32'h4, 32'h8);
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h43) $display("[TB] FAIL ovf_status_cleared: got 0x%08h, required 0x00000043", st);
    else passes++;
    while (cycleCount < c0 + FRAME_CYCLES) @(negedge clk);
    busWrite(BASE, 32'h26);
    expQ.push_back(8'h26);
    busRead(BASE + 32'h4, st, s);
    checks++;
    if (st !== 32'h43) $display("[TB] FAIL ovf_full_push_pop: got 0x%08h, required 0x00000043", st);
    else passes++;
    waitDrain(6 * FRAME_CYCLES + 20, "ovf_drain");
  endtask

  // Watchdog so the bench always terminates.
  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    test_reset();
    test_decode();
    test_single_frame(8'h55, "single55");
`ifdef UART_TX_PARITY_EN
    test_single_frame(8'h07, "parity07");
`endif
    test_back_to_back();
    test_overflow();
    checks++;
    if (expQ.size() != 0) $display("[TB] FAIL scoreboard_empty: %0d bytes outstanding, required 0", expQ.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data bus, downstream of the `arm` core. It decodes `Adr`, `MemWrite` and `WriteData` from the core and buffers bytes in a small FIFO. It serialises the bytes as 8N1 frames on `tx`, and returns a status word over a combinational read path that the top level muxes into `ReadData`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: 16-byte-aligned base of the register window.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be at least 2.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  bus write strobe from the core.
- `Adr`  in  32  bus address from the core.
- `WriteData`  in  32  bus write data from the core.
- `Sel`  out  1  combinational; 1 when `Adr[31:4] == BASE_ADDR[31:4]`.
- `RdData`  out  32  combinational read data; 0 when `Sel` is 0.
- `tx`  out  1  registered serial line; idle level is high.

## Operation
- Register map by `Adr[3:2]`; `Adr[1:0]` are ignored:
  - 0x0 TXDATA, write-only: push `WriteData[7:0]` into the FIFO. Reads return 0.
  - 0x4 STATUS, read: bit0 busy (FSM not in IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, all other bits 0. Writing with `WriteData[3]=1` clears overflow.
  - 0x8 and 0xC: reads return 0; writes are ignored.
- Push condition: `Sel & MemWrite & (Adr[3:2]==0)`.
  - FIFO full with no pop in the same cycle: the byte is dropped and overflow is set.
  - FIFO full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - The FIFO uses circular read and write pointers that wrap modulo `FIFO_DEPTH`.
- If an overflow-setting push and a clear write coincide, the clear wins. This cannot actually happen, because the two target different addresses.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE with the FIFO non-empty: pop into the shift register, go to START, drive `tx`=0.
  - START: after `CLKS_PER_BIT` cycles go to DATA and drive `tx` with bit0.
  - DATA: send 8 bits LSB first, each held `CLKS_PER_BIT` cycles, with a 3-bit bit counter. After bit7 go to STOP and drive `tx`=1.
  - STOP: after `CLKS_PER_BIT` cycles, if the FIFO is non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- The baud counter reloads to `CLKS_PER_BIT-1` on every state or bit change and decrements to 0.

## Timing
- Reset values: `tx`=1, FSM in IDLE, FIFO empty (pointers and count 0), overflow=0, baud counter 0, shift register 0.
- Reset is asynchronous. Asserting it mid-frame aborts the frame immediately: `tx` returns high and the FIFO contents are discarded.
- Write-to-line latency: push at edge N (FIFO previously empty, FSM in IDLE), pop at edge N+1, `tx` falls after edge N+1.
- One frame is exactly 10×`CLKS_PER_BIT` cycles (11× with parity). Back-to-back frames have no idle cycles between them.
- STATUS reflects register state combinationally: a read in the cycle after a push shows the updated count.
- A push in the same cycle as a pop from a one-entry FIFO leaves count=1.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: adds a PARITY state between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles, giving 8E1 frames of 11 bit-times.
  - Undefined: 8N1 with no PARITY state.

## Test plan
- Reset while `tx` is low mid-frame → `tx`=1 immediately and STATUS reads 0x0000_0004 after reset is released.
- Write 0x55 to BASE_ADDR with `CLKS_PER_BIT`=4 → `tx` falls one cycle later. Line shows 0,1,0,1,0,1,0,1,0,1 at 4-cycle intervals, then idles; busy=0 after 40 cycles.
- Write 0xA1, 0xB2, 0xC3 on consecutive cycles → three contiguous frames with no idle gap between stop and start bits; empty=1 after 120 cycles.
- Five writes while FIFO_DEPTH=4 and the FSM is busy with an earlier byte → four bytes are accepted, the fifth is dropped, STATUS bit3=1. A write of 0x8 to BASE+4 clears bit3.
- Read BASE+8 and an address outside the window (0x0000_0100) → RdData=0; `Sel`=1 and `Sel`=0 respectively.
- With `UART_TX_PARITY_EN` defined, write 0x07 → parity bit=1 and frame length is 44 cycles at `CLKS_PER_BIT`=4.
